// File: rtl/tmds_channel_rx_pkg.sv
// Shared TMDS definitions: control tokens, bit-offset range and the receiver FSM state type.
// Both the encoder and the receive path import this package, so each token is defined once.
package tmds_channel_rx_pkg;
    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    localparam logic [3:0] OFFSET_MIN = 4'd0;
    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic {ST_SEARCH, ST_LOCKED} rx_state_t;

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= OFFSET_MAX) ? OFFSET_MIN : off + 4'd1;
    endfunction
endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b -> 8b decode of one aligned word.
// Control tokens report is_ctrl with their 2-bit value; anything else decodes as video data.
module tmds_word_decode
    import tmds_channel_rx_pkg::*;
(
    input  logic [9:0] i_tmds,
    output logic       o_is_ctrl,
    output logic [1:0] o_ctrl,
    output logic [7:0] o_data
);
    logic [7:0] w_d;

    always_comb begin
        o_is_ctrl = 1'b1;
        o_ctrl    = 2'b00;
        o_data    = 8'h00;
        w_d       = i_tmds[7:0] ^ {8{i_tmds[9]}};
        case (i_tmds)
            TOK_00: o_ctrl = 2'b00;
            TOK_01: o_ctrl = 2'b01;
            TOK_10: o_ctrl = 2'b10;
            TOK_11: o_ctrl = 2'b11;
            default: begin
                o_is_ctrl = 1'b0;
                o_data[0] = w_d[0];
                // bit 8 selects XOR vs XNOR chaining used by the encoder
                for (int i = 1; i < 8; i++)
                    o_data[i] = i_tmds[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
            end
        endcase
    end
endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: bit-slip word alignment on blanking tokens, then decode.
// Outputs are held at zero whenever alignment is not established.
module tmds_channel_rx
    import tmds_channel_rx_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int DWELL      = 2048,
    parameter int DWELL_W    = 12
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset,
    output logic       lost
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    rx_state_t          r_state, w_state_nxt;
    logic [9:0]         r_raw_prev, r_aligned;
    logic [3:0]         r_offset;
    logic [RUN_W-1:0]   r_run, w_run_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_slip_d, r_lost, r_de;
    logic [7:0]         r_data;
    logic [1:0]         r_ctrl;

    // Padded so an (unreachable) offset above 9 never indexes past the vector
    logic [24:0] w_win;
    logic [9:0]  w_sel;
    logic        w_is_ctrl, w_run_full, w_dwell_up, w_slip;
    logic [1:0]  w_ctrl;
    logic [7:0]  w_data;

    assign w_win = {5'b0, raw_in, r_raw_prev};
    assign w_sel = w_win[r_offset +: 10];

    tmds_word_decode u_dec (
        .i_tmds    (r_aligned),
        .o_is_ctrl (w_is_ctrl),
        .o_ctrl    (w_ctrl),
        .o_data    (w_data)
    );

    // A full token run outranks an expiring dwell timer
    assign w_run_full = (r_run == RUN_W'(LOCK_COUNT));
    assign w_dwell_up = (r_dwell == DWELL_W'(DWELL));
    assign w_slip     = w_dwell_up && !w_run_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: if (w_run_full) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_slip)     w_state_nxt = ST_SEARCH;
            default:                   w_state_nxt = ST_SEARCH;
        endcase
    end

    // The word in r_aligned right after a slip was taken at the old offset
    always_comb begin
        w_run_nxt = '0;
        if (!w_slip && !r_slip_d && w_is_ctrl)
            w_run_nxt = w_run_full ? r_run : r_run + RUN_W'(1);
        w_dwell_nxt = (w_slip || w_run_full) ? '0 : r_dwell + DWELL_W'(1);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SEARCH;
            r_raw_prev <= '0;
            r_aligned  <= '0;
            r_offset   <= OFFSET_MIN;
            r_run      <= '0;
            r_dwell    <= '0;
            r_slip_d   <= 1'b0;
            r_lost     <= 1'b0;
            r_de       <= 1'b0;
            r_data     <= '0;
            r_ctrl     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_raw_prev <= raw_in;
            r_aligned  <= w_sel;
            r_run      <= w_run_nxt;
            r_dwell    <= w_dwell_nxt;
            r_slip_d   <= w_slip;
            r_lost     <= w_slip && (r_state == ST_LOCKED);
            if (w_slip)
                r_offset <= next_offset(r_offset);
            // Gate on the next state so outputs drop on the same cycle as locked
            if (w_state_nxt != ST_LOCKED) begin
                r_de   <= 1'b0;
                r_data <= '0;
                r_ctrl <= '0;
            end else if (w_is_ctrl) begin
                r_de   <= 1'b0;
                r_data <= '0;
                r_ctrl <= w_ctrl;
            end else begin
                r_de   <= 1'b1;
                r_data <= w_data;
            end
        end
    end

    assign data   = r_data;
    assign ctrl   = r_ctrl;
    assign de     = r_de;
    assign locked = (r_state == ST_LOCKED);
    assign offset = r_offset;
    assign lost   = r_lost;
endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx: lock, misalignment search, decode, loss/wrap,
// lock-vs-slip priority and asynchronous reset while locked.
module tb_tmds_channel_rx;
    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [9:0] raw_in  = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de, locked, lost;
    logic [3:0] offset;
    int total = 0;
    int bad   = 0;

    tmds_channel_rx #(.LOCK_COUNT(16), .DWELL(64), .DWELL_W(12)) dut (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .raw_in  (raw_in),
        .data    (data),
        .ctrl    (ctrl),
        .de      (de),
        .locked  (locked),
        .offset  (offset),
        .lost    (lost)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step(input int n);
        repeat (n) @(posedge clk_pix);
        #1;
    endtask

    // Word seen per clock when a repeating token is delayed k bits on the serial line
    function automatic logic [9:0] delayed(input logic [9:0] tok, input int k);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = tok[(b - k + 10) % 10];
        return r;
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        raw_in = '0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_lock(input string name, input int bound);
        for (int i = 0; i < bound && locked !== 1'b1; i++) step(1);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL %s lock timeout locked=%b exp 1", name, locked); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; raw_in = '0;
        step(2);
        total++; if (data !== 8'h00)  begin bad++; $display("FAIL reset data got %h exp 00", data); end
        total++; if (ctrl !== 2'b00)  begin bad++; $display("FAIL reset ctrl got %b exp 00", ctrl); end
        total++; if (de !== 1'b0)     begin bad++; $display("FAIL reset de got %b exp 0", de); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset locked got %b exp 0", locked); end
        total++; if (offset !== 4'd0) begin bad++; $display("FAIL reset offset got %0d exp 0", offset); end
        total++; if (lost !== 1'b0)   begin bad++; $display("FAIL reset lost got %b exp 0", lost); end
        step(1);
        rst_n = 1'b1;
    endtask

    // Token enters raw_prev at edge 1, r_aligned at 2; run hits 16 at edge 18, lock at 19
    task automatic test_aligned_lock();
        raw_in = T00;
        step(18);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL aligned early_lock got %b exp 0", locked); end
        step(1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL aligned locked got %b exp 1", locked); end
        step(1);
        total++; if (offset !== 4'd0) begin bad++; $display("FAIL aligned offset got %0d exp 0", offset); end
        total++; if (ctrl !== 2'b00)  begin bad++; $display("FAIL aligned ctrl got %b exp 00", ctrl); end
        total++; if (de !== 1'b0)     begin bad++; $display("FAIL aligned de got %b exp 0", de); end
        total++; if (lost !== 1'b0)   begin bad++; $display("FAIL aligned lost got %b exp 0", lost); end
    endtask

    // Each word held 3 clocks so the check lands inside its output window
    task automatic test_data_decode();
        raw_in = T10; step(4);
        total++; if (ctrl !== 2'b10) begin bad++; $display("FAIL decode ctrl10 got %b exp 10", ctrl); end
        raw_in = 10'h100; step(3);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL decode d100 data got %h exp 00", data); end
        total++; if (de !== 1'b1)    begin bad++; $display("FAIL decode d100 de got %b exp 1", de); end
        total++; if (ctrl !== 2'b10) begin bad++; $display("FAIL decode d100 ctrl_hold got %b exp 10", ctrl); end
        raw_in = 10'h200; step(3);
        total++; if (data !== 8'hFF) begin bad++; $display("FAIL decode d200 data got %h exp ff", data); end
        total++; if (de !== 1'b1)    begin bad++; $display("FAIL decode d200 de got %b exp 1", de); end
        raw_in = T00; step(3);
        total++; if (de !== 1'b0)     begin bad++; $display("FAIL decode back_to_ctrl de got %b exp 0", de); end
        total++; if (ctrl !== 2'b00)  begin bad++; $display("FAIL decode back_to_ctrl ctrl got %b exp 00", ctrl); end
        total++; if (data !== 8'h00)  begin bad++; $display("FAIL decode back_to_ctrl data got %h exp 00", data); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL decode locked got %b exp 1", locked); end
    endtask

    task automatic test_misaligned();
        do_reset();
        raw_in = delayed(T11, 3);
        wait_lock("misalign", 1000);
        total++; if (offset !== 4'd3) begin bad++; $display("FAIL misalign offset got %0d exp 3", offset); end
        step(3);
        total++; if (ctrl !== 2'b11) begin bad++; $display("FAIL misalign ctrl got %b exp 11", ctrl); end
        total++; if (de !== 1'b0)    begin bad++; $display("FAIL misalign de got %b exp 0", de); end
    endtask

    task automatic test_loss_wrap();
        do_reset();
        raw_in = delayed(T11, 9);
        wait_lock("wrap", 1500);
        total++; if (offset !== 4'd9) begin bad++; $display("FAIL wrap lock_offset got %0d exp 9", offset); end
        step(3);
        raw_in = 10'h100;
        for (int i = 0; i < 300 && lost !== 1'b1; i++) step(1);
        total++; if (lost !== 1'b1)   begin bad++; $display("FAIL wrap lost got %b exp 1", lost); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL wrap locked got %b exp 0", locked); end
        total++; if (offset !== 4'd0) begin bad++; $display("FAIL wrap offset got %0d exp 0", offset); end
        total++; if (de !== 1'b0)     begin bad++; $display("FAIL wrap de got %b exp 0", de); end
        total++; if (data !== 8'h00)  begin bad++; $display("FAIL wrap data got %h exp 00", data); end
        total++; if (ctrl !== 2'b00)  begin bad++; $display("FAIL wrap ctrl got %b exp 00", ctrl); end
        step(1);
        total++; if (lost !== 1'b0)   begin bad++; $display("FAIL wrap lost_width got %b exp 0", lost); end
    endtask

    // First token before edge 47 -> run=16 and dwell=64 together after edge 64
    task automatic test_boundary();
        do_reset();
        raw_in = '0;
        step(46);
        raw_in = T00;
        step(18);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL boundary pre locked got %b exp 0", locked); end
        step(1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL boundary locked got %b exp 1", locked); end
        total++; if (offset !== 4'd0) begin bad++; $display("FAIL boundary offset got %0d exp 0", offset); end
    endtask

    task automatic test_reset_midlock();
        do_reset();
        raw_in = delayed(T11, 5);
        wait_lock("midlock", 1000);
        step(3);
        total++; if (offset !== 4'd5) begin bad++; $display("FAIL midlock offset got %0d exp 5", offset); end
        total++; if (ctrl !== 2'b11)  begin bad++; $display("FAIL midlock ctrl got %b exp 11", ctrl); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midlock_rst locked got %b exp 0", locked); end
        total++; if (offset !== 4'd0) begin bad++; $display("FAIL midlock_rst offset got %0d exp 0", offset); end
        total++; if (ctrl !== 2'b00)  begin bad++; $display("FAIL midlock_rst ctrl got %b exp 00", ctrl); end
        total++; if (de !== 1'b0 || data !== 8'h00 || lost !== 1'b0) begin
            bad++; $display("FAIL midlock_rst de/data/lost got %b/%h/%b exp 0/00/0", de, data, lost);
        end
        raw_in = '0;
        step(2);
        rst_n  = 1'b1;
        raw_in = T00;
        step(18);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock early got %b exp 0", locked); end
        step(1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock got %b exp 1", locked); end
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_data_decode();
        test_misaligned();
        test_loss_wrap();
        test_boundary();
        test_reset_midlock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
